// File: rtl/mc_controller.sv
// mc_controller: multicycle main control FSM for the mim datapath.
// Sequences fetch/decode/execute/memory/writeback, drives datapath
// mux selects, enables and memory strobes, and counts retired instructions.
// Optional feature macro: MC_CTRL_MEMWAIT_EN. When it is defined, mem_ready
// stalls FETCH/MEMRD/MEMWR. When it is undefined, each of those states
// lasts exactly one cycle.
module mc_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [2:0]       alu_op,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
        MEMWB = 4'd5, MEMWR = 4'd6, RTEX = 4'd7, RTWB = 4'd8, BEQ = 4'd9,
        JMP = 4'd10, IEX = 4'd11, IWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RT = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                           OP_ANDI = 6'b001100, OP_ORI = 6'b001101;

    state_t     st;
    logic [5:0] op_q;     // opcode captured in DECODE; IR may change later
    logic       rdy;
    logic       unused_ok;

`ifdef MC_CTRL_MEMWAIT_EN
    assign rdy = mem_ready;
    assign unused_ok = zero;
`else
    assign rdy = 1'b1;
    assign unused_ok = zero ^ mem_ready;
`endif

    // zero is consumed by the datapath's PC-enable gate, not by the FSM
    assign state = st;

    // State sequencing, decoded-opcode hold and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            op_q    <= '0;
            retired <= '0;
        end else begin
            case (st)
                IDLE:   st <= FETCH;
                FETCH:  if (rdy) st <= DECODE;
                DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_RT:                    st <= RTEX;
                        OP_LW, OP_SW:             st <= MEMADR;
                        OP_BEQ:                   st <= BEQ;
                        OP_J:                     st <= JMP;
                        OP_ADDI, OP_ANDI, OP_ORI: st <= IEX;
                        default:                  st <= FETCH;
                    endcase
                end
                MEMADR: st <= (op_q == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  if (rdy) st <= MEMWB;
                MEMWB:  st <= FETCH;
                MEMWR:  if (rdy) st <= FETCH;
                RTEX:   st <= RTWB;
                RTWB:   st <= FETCH;
                BEQ:    st <= FETCH;
                JMP:    st <= FETCH;
                IEX:    st <= IWB;
                IWB:    st <= FETCH;
                default: st <= IDLE;
            endcase
            if (st == MEMWB || st == RTWB || st == BEQ || st == JMP || st == IWB ||
                (st == MEMWR && rdy))
                retired <= retired + 1'b1;
        end
    end

    // Per-state datapath controls; anything not set in a state stays 0
    always_comb begin
        pc_write = 1'b0; pc_write_cond = 1'b0; i_or_d = 1'b0; mem_read = 1'b0;
        mem_write = 1'b0; ir_write = 1'b0; mem_to_reg = 1'b0; reg_dst = 1'b0;
        reg_write = 1'b0; alu_src_a = 1'b0; alu_src_b = 2'b00; pc_source = 2'b00;
        alu_op = 3'b000; illegal = 1'b0;
        case (st)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = rdy;
                pc_write  = rdy;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RT, OP_LW, OP_SW, OP_BEQ, OP_J,
                    OP_ADDI, OP_ANDI, OP_ORI: illegal = 1'b0;
                    default:                  illegal = 1'b1;
                endcase
            end
            MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
            MEMRD:  begin mem_read = 1'b1; i_or_d = 1'b1; end
            MEMWB:  begin reg_write = 1'b1; mem_to_reg = 1'b1; end
            MEMWR:  begin mem_write = 1'b1; i_or_d = 1'b1; end
            RTEX:   begin alu_src_a = 1'b1; alu_op = 3'b111; end
            RTWB:   begin reg_write = 1'b1; reg_dst = 1'b1; end
            BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b001;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JMP:    begin pc_write = 1'b1; pc_source = 2'b10; end
            IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_ANDI: alu_op = 3'b010;
                    OP_ORI:  alu_op = 3'b011;
                    default: alu_op = 3'b000;
                endcase
            end
            IWB:    reg_write = 1'b1;
            default: ;
        endcase
    end
endmodule
